// File: rtl/mux2_arbiter.sv
// mux2_arbiter
//   Two-channel valid/ready arbiter with a single registered output stage.
//   Under contention the channel that did not win last time gets the grant,
//   so two permanently requesting channels alternate word by word. The
//   registered sel output steers a downstream mux2 data path.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   in0_data/valid/ready : channel 0 request interface
//   in1_data/valid/ready : channel 1 request interface
//   out_data/valid/ready : output interface (registered data, sel and valid)
//   sel                  : channel index of the word currently in out_data
//   gnt_cnt0, gnt_cnt1   : saturating 8-bit per-channel grant counters,
//                          present only when MUX2_ARBITER_GNT_CNT_EN is defined
//
// Optional feature macro: MUX2_ARBITER_GNT_CNT_EN

module mux2_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel
`ifdef MUX2_ARBITER_GNT_CNT_EN
    ,
    output logic [7:0]       gnt_cnt0,
    output logic [7:0]       gnt_cnt1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             sel_q, sel_d;
    logic             last_sel_q, last_sel_d;

    logic can_load;
    logic fire0, fire1, load;

    // Output stage can take a new word when empty or when being drained now.
    assign can_load = (state_q == EMPTY) || out_ready;

    // A channel's ready is derived only from the other channel's valid and
    // the priority pointer, never from its own valid. Under contention
    // exactly one ready is high; a single requester always sees its ready.
    // Readies are forced low while reset is asserted.
    assign in0_ready = rst_n && can_load && (!in1_valid ||  last_sel_q);
    assign in1_ready = rst_n && can_load && (!in0_valid || !last_sel_q);

    // The ready terms above are mutually exclusive whenever both request,
    // so at most one channel fires per cycle.
    assign fire0 = in0_valid && in0_ready;
    assign fire1 = in1_valid && in1_ready;
    assign load  = fire0 || fire1;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;

        case (state_q)
            EMPTY: if (load) state_d = FULL;
            FULL: begin
                if (load)           state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase

        if (load) begin
            out_data_d = fire1 ? in1_data : in0_data;
            sel_d      = fire1;
            last_sel_d = fire1;
        end
    end

    // last_sel resets to 1 so channel 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            sel_q      <= 1'b0;
            last_sel_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = (state_q == FULL);
    assign sel       = sel_q;

`ifdef MUX2_ARBITER_GNT_CNT_EN
    logic [7:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [7:0] gnt_cnt1_q, gnt_cnt1_d;

    // Counters stick at 255 rather than wrapping.
    always_comb begin
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        if (fire0 && (gnt_cnt0_q != 8'hFF)) gnt_cnt0_d = gnt_cnt0_q + 8'd1;
        if (fire1 && (gnt_cnt1_q != 8'hFF)) gnt_cnt1_d = gnt_cnt1_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0_q <= 8'd0;
            gnt_cnt1_q <= 8'd0;
        end else begin
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each channel.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in0_data  input  WIDTH  channel 0 payload.
REQ-005 Port: in0_valid  input  1  channel 0 request.
REQ-006 Port: in0_ready  output  1  channel 0 accepted this cycle when high with in0_valid.
REQ-007 Port: in1_data / in1_valid / in1_ready  same as REQ-004..006 for channel 1.
REQ-008 Port: out_data  output  WIDTH  registered selected payload, feeds downstream mux2 data path.
REQ-009 Port: out_valid  output  1  out_data holds an unconsumed word.
REQ-010 Port: out_ready  input  1  downstream consumes when out_valid and out_ready both high.
REQ-011 Port: sel  output  1  registered channel index of the word in out_data (0 or 1); drives mux2 select.

Function
REQ-012 Output stage SHALL be a single register; it "can load" when out_valid=0 or (out_valid=1 and out_ready=1).
REQ-013 State machine SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 EMPTY->FULL on a load; FULL->EMPTY when out_ready=1 and no load; FULL->FULL on simultaneous drain and load.
REQ-015 Grant is combinational: when "can load", it goes to the single valid channel; if both are valid, it goes to the channel not equal to the priority pointer last_sel.
REQ-016 inN_ready SHALL be high only for the granted channel and only while "can load"; the other ready SHALL be low.
REQ-017 On a load, out_data/sel SHALL take the granted channel's data/index at the next edge (latency 1 cycle), and last_sel SHALL update to the granted index.
REQ-018 When FULL and out_ready=0, out_data, sel and out_valid SHALL hold, and both in0_ready and in1_ready SHALL be 0.
REQ-019 Throughput SHALL be one word per cycle with out_ready held high and at least one valid input.
REQ-020 With both inputs continuously valid and out_ready=1, grants SHALL strictly alternate.
REQ-021 Input readies SHALL NOT depend combinationally on the same channel's valid; they MAY depend on the other channel's valid and on out_ready.
REQ-022 No word SHALL be dropped or duplicated; each accepted input appears exactly once at the output.

Reset
REQ-023 While rst_n=0: out_valid=0, out_data=0, sel=0, last_sel=1 (so channel 0 wins the first contention), state EMPTY, in0_ready=in1_ready=0.
REQ-024 Reset assertion mid-transfer SHALL discard the held word immediately, without waiting for a clock edge.
REQ-025 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro MUX2_ARBITER_GNT_CNT_EN: when defined, adds outputs gnt_cnt0 and gnt_cnt1 (8 bits each).
REQ-027 Each counter increments on every load from its channel, saturates at 255, and resets to 0.
REQ-028 When the macro is undefined, these ports and their logic are absent; all other behaviour is identical.

Verification
REQ-029 Reset, then in0_valid=1 with data 8'hA5, in1_valid=0, out_ready=1 -> next cycle out_valid=1, out_data=A5, sel=0.
REQ-030 Both valid (in0=8'h11, in1=8'h22), out_ready=1 for 4 cycles, starting from reset -> outputs 11,22,11,22 and sel toggles 0,1,0,1.
REQ-031 FULL with out_ready=0 for 3 cycles -> out_data holds, both readies 0; then out_ready=1 -> held word is consumed and a new word is loaded in the same cycle.
REQ-032 Assert rst_n=0 asynchronously between edges while FULL -> out_valid falls to 0 immediately, with no clock edge required.
REQ-033 With MUX2_ARBITER_GNT_CNT_EN defined, 300 consecutive channel-1-only transfers -> gnt_cnt1=255, gnt_cnt0=0.
REQ-034 Random valid/ready stimulus over 1000 cycles -> scoreboard confirms order per channel, no loss or duplication, and alternation under contention.
